sync_fifo_ctrl: RTL and testbench

- Single-clock first-in-first-out buffer with push/pop handshake and full/empty status flags.
- Sits between a producer and a consumer in the same clock domain.
- Replaces the dual-clock wrapper interface: the former write and read clocks and resets are merged into one clock and one reset.
- Storage is a register array indexed by binary read/write pointers, each one bit wider than the address.

---
 rtl/sync_fifo_ctrl_if.sv | 44 ++++
 rtl/sync_fifo_ctrl.sv | 95 +++++++++
 tb/tb_sync_fifo_ctrl.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sync_fifo_ctrl_if.sv
// Push/pop handshake bundle for sync_fifo_ctrl.
// overflow/underflow exist only when FIFO_ERR_FLAGS_EN is defined.
interface sync_fifo_ctrl_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] data_in;
    logic                  push;
    logic                  full;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  pop;
    logic                  empty;
`ifdef FIFO_ERR_FLAGS_EN
    logic                  overflow;
    logic                  underflow;
`endif

    // master: producer/consumer side that drives requests
    modport master (
        output data_in,
        output push,
        output pop,
        input  full,
        input  empty,
`ifdef FIFO_ERR_FLAGS_EN
        input  overflow,
        input  underflow,
`endif
        input  data_out
    );

    // slave: the FIFO itself
    modport slave (
        input  data_in,
        input  push,
        input  pop,
        output full,
        output empty,
`ifdef FIFO_ERR_FLAGS_EN
        output overflow,
        output underflow,
`endif
        output data_out
    );
endinterface

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO with registered read data and full/empty flags.
// Optional FIFO_ERR_FLAGS_EN adds registered overflow/underflow pulses.
module sync_fifo_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16   // power of two, >= 2
) (
    input  logic                   clk,
    input  logic                   rst,     // asynchronous, active low
    sync_fifo_ctrl_if.slave        bus
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [ADDR_W:0]       wr_ptr_reg, wr_ptr_next;
    logic [ADDR_W:0]       rd_ptr_reg, rd_ptr_next;
    logic [DATA_WIDTH-1:0] data_out_reg, data_out_next;

    logic full_int;
    logic empty_int;
    logic push_ok;
    logic pop_ok;

    // Extra pointer MSB distinguishes a full buffer from an empty one.
    assign empty_int = (wr_ptr_reg == rd_ptr_reg);
    assign full_int  = (wr_ptr_reg[ADDR_W] != rd_ptr_reg[ADDR_W]) &&
                       (wr_ptr_reg[ADDR_W-1:0] == rd_ptr_reg[ADDR_W-1:0]);

    // A pop frees a slot in the same cycle, so a push on a full FIFO
    // succeeds when paired with a pop. Pop on empty never sees the
    // word being pushed in that same cycle.
    assign pop_ok  = bus.pop && !empty_int;
    assign push_ok = bus.push && (!full_int || pop_ok);

    always_comb begin
        wr_ptr_next   = wr_ptr_reg;
        rd_ptr_next   = rd_ptr_reg;
        data_out_next = data_out_reg;
        if (push_ok) begin
            wr_ptr_next = wr_ptr_reg + PTR_ONE;
        end
        if (pop_ok) begin
            rd_ptr_next   = rd_ptr_reg + PTR_ONE;
            data_out_next = mem[rd_ptr_reg[ADDR_W-1:0]];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            data_out_reg <= '0;
        end else begin
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
            data_out_reg <= data_out_next;
        end
    end

    // Storage has no reset; stale contents are unreachable once pointers clear.
    always_ff @(posedge clk) begin
        if (push_ok && rst) begin
            mem[wr_ptr_reg[ADDR_W-1:0]] <= bus.data_in;
        end
    end

    assign bus.full     = full_int;
    assign bus.empty    = empty_int;
    assign bus.data_out = data_out_reg;

`ifdef FIFO_ERR_FLAGS_EN
    logic overflow_reg, overflow_next;
    logic underflow_reg, underflow_next;

    always_comb begin
        overflow_next  = bus.push && !push_ok;
        underflow_next = bus.pop && empty_int;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            overflow_reg  <= overflow_next;
            underflow_reg <= underflow_next;
        end
    end

    assign bus.overflow  = overflow_reg;
    assign bus.underflow = underflow_reg;
`endif

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Directed self-checking bench for sync_fifo_ctrl (DEPTH=16, DATA_WIDTH=8).
module tb_sync_fifo_ctrl;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    sync_fifo_ctrl_if #(.DATA_WIDTH(8)) bus ();

    sync_fifo_ctrl #(.DATA_WIDTH(8), .DEPTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.push = 1'b0;
        bus.pop  = 1'b0;
    endtask

    task automatic chk_flags(input string name, input logic exp_empty, input logic exp_full);
        n_cmp++;
        if (bus.empty !== exp_empty || bus.full !== exp_full) begin
            n_err++;
            $display("FAIL %s: empty=%b full=%b, required empty=%b full=%b",
                     name, bus.empty, bus.full, exp_empty, exp_full);
        end
    endtask

    task automatic chk_data(input string name, input logic [7:0] exp);
        n_cmp++;
        if (bus.data_out !== exp) begin
            n_err++;
            $display("FAIL %s: data_out=%h, required %h", name, bus.data_out, exp);
        end
    endtask

    task automatic test_reset();
        idle();
        bus.data_in = 8'h00;
        rst = 1'b0;
        step();
        rst = 1'b1;
        step();
        // Some traffic, then an asynchronous mid-cycle reset.
        bus.push = 1'b1; bus.data_in = 8'h33; step();
        bus.data_in = 8'h44; step();
        bus.push = 1'b0; bus.pop = 1'b1; step();
        idle();
        chk_data("reset_pre_data", 8'h33);
        #2 rst = 1'b0;
        #1;
        chk_flags("reset_async_flags", 1'b1, 1'b0);
        chk_data("reset_async_data", 8'h00);
        step();
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk_flags("reset_idle_flags", 1'b1, 1'b0);
            chk_data("reset_idle_data", 8'h00);
        end
        $display("test_reset done: compared=%0d mismatched=%0d", n_cmp, n_err);
    endtask

    task automatic test_ordered();
        for (int i = 1; i <= 5; i++) begin
            bus.push = 1'b1; bus.data_in = 8'(i);
            step();
            chk_flags("ordered_push_flags", 1'b0, 1'b0);
        end
        idle();
        for (int i = 1; i <= 5; i++) begin
            bus.pop = 1'b1;
            step();
            chk_data("ordered_pop_data", 8'(i));
            $display("ordered pop %0d: data_out=%h", i, bus.data_out);
        end
        idle();
        chk_flags("ordered_final_empty", 1'b1, 1'b0);
    endtask

    task automatic test_overflow();
        int ovf_cnt;
        int unf_cnt;
        ovf_cnt = 0;
        unf_cnt = 0;
        for (int k = 1; k <= 21; k++) begin
            bus.push = 1'b1; bus.data_in = 8'(k - 1);
            step();
            chk_flags("overflow_push_flags", 1'b0, (k >= 16));
`ifdef FIFO_ERR_FLAGS_EN
            n_cmp++;
            if (bus.overflow !== (k >= 17)) begin
                n_err++;
                $display("FAIL overflow_pulse k=%0d: overflow=%b, required %b", k, bus.overflow, (k >= 17));
            end
            if (bus.overflow === 1'b1) ovf_cnt++;
`endif
        end
        idle();
        for (int k = 1; k <= 21; k++) begin
            bus.pop = 1'b1;
            step();
            chk_data("overflow_pop_data", (k <= 16) ? 8'(k - 1) : 8'd15);
            chk_flags("overflow_pop_flags", (k >= 16), 1'b0);
`ifdef FIFO_ERR_FLAGS_EN
            n_cmp++;
            if (bus.underflow !== (k >= 17)) begin
                n_err++;
                $display("FAIL underflow_pulse k=%0d: underflow=%b, required %b", k, bus.underflow, (k >= 17));
            end
            if (bus.underflow === 1'b1) unf_cnt++;
`endif
        end
        idle();
        step();
`ifdef FIFO_ERR_FLAGS_EN
        n_cmp++;
        if (ovf_cnt != 5 || unf_cnt != 5 || bus.underflow !== 1'b0) begin
            n_err++;
            $display("FAIL err_flag_counts: overflow=%0d underflow=%0d last=%b, required 5/5/0",
                     ovf_cnt, unf_cnt, bus.underflow);
        end
`endif
        $display("test_overflow done: compared=%0d mismatched=%0d", n_cmp, n_err);
    endtask

    task automatic test_underflow();
        for (int i = 0; i < 16; i++) begin
            bus.push = 1'b1; bus.data_in = 8'(8'h80 + i);
            step();
        end
        idle();
        chk_flags("underflow_filled", 1'b0, 1'b1);
        for (int k = 1; k <= 21; k++) begin
            bus.pop = 1'b1;
            step();
            chk_data("underflow_pop_data", 8'(8'h80 + ((k <= 16) ? k - 1 : 15)));
        end
        idle();
        chk_flags("underflow_final", 1'b1, 1'b0);
        // Pointers unchanged by ignored pops: a fresh word round-trips.
        bus.push = 1'b1; bus.data_in = 8'h5C; step();
        idle();
        chk_flags("underflow_one_word", 1'b0, 1'b0);
        bus.pop = 1'b1; step();
        idle();
        chk_data("underflow_roundtrip", 8'h5C);
        chk_flags("underflow_roundtrip_empty", 1'b1, 1'b0);
        $display("test_underflow done: compared=%0d mismatched=%0d", n_cmp, n_err);
    endtask

    task automatic test_simultaneous();
        for (int i = 0; i < 16; i++) begin
            bus.push = 1'b1; bus.data_in = 8'(8'h10 + i);
            step();
        end
        chk_flags("simul_full_before", 1'b0, 1'b1);
        bus.push = 1'b1; bus.pop = 1'b1; bus.data_in = 8'hAA;
        step();
        idle();
        chk_data("simul_full_oldest", 8'h10);
        chk_flags("simul_full_after", 1'b0, 1'b1);
`ifdef FIFO_ERR_FLAGS_EN
        n_cmp++;
        if (bus.overflow !== 1'b0) begin
            n_err++;
            $display("FAIL simul_full_no_overflow: overflow=%b, required 0", bus.overflow);
        end
`endif
        for (int k = 1; k <= 16; k++) begin
            bus.pop = 1'b1;
            step();
            chk_data("simul_drain", (k <= 15) ? 8'(8'h10 + k) : 8'hAA);
        end
        idle();
        chk_flags("simul_drained", 1'b1, 1'b0);
        bus.push = 1'b1; bus.pop = 1'b1; bus.data_in = 8'h55;
        step();
        idle();
        chk_flags("simul_empty_after", 1'b0, 1'b0);
        chk_data("simul_empty_no_forward", 8'hAA);
        bus.pop = 1'b1; step();
        idle();
        chk_data("simul_empty_word", 8'h55);
        chk_flags("simul_empty_final", 1'b1, 1'b0);
        $display("test_simultaneous done: compared=%0d mismatched=%0d", n_cmp, n_err);
    endtask

    // Fill to 16, stream 24 words at constant occupancy, drain: 40 words, pointers wrap.
    task automatic test_wrap();
        logic [7:0] model_q[$];
        logic [7:0] exp;
        int wr_idx;
        wr_idx = 0;
        for (int c = 0; c < 56; c++) begin
            bus.push = (c < 40);
            bus.pop  = (c >= 16);
            bus.data_in = 8'((wr_idx * 7 + 3) & 8'hFF);
            if (bus.pop) exp = model_q.pop_front();
            if (bus.push) begin
                model_q.push_back(bus.data_in);
                wr_idx++;
            end
            step();
            if (c >= 16) chk_data("wrap_data", exp);
            chk_flags("wrap_flags", (model_q.size() == 0), (model_q.size() == 16));
        end
        idle();
        $display("test_wrap done: compared=%0d mismatched=%0d", n_cmp, n_err);
    endtask

    task automatic test_reset_recovery();
        for (int i = 0; i < 5; i++) begin
            bus.push = 1'b1; bus.data_in = 8'(8'hC0 + i);
            step();
        end
        bus.push = 1'b0; bus.pop = 1'b1; step();
        step();
        chk_data("recov_pre_data", 8'hC1);
        // In-flight push held across the reset edge must be lost.
        bus.pop = 1'b0; bus.push = 1'b1; bus.data_in = 8'hEE;
        #2 rst = 1'b0;
        #1;
        chk_flags("recov_async_flags", 1'b1, 1'b0);
        chk_data("recov_async_data", 8'h00);
        step();
        idle();
        rst = 1'b1;
        step();
        chk_flags("recov_after_release", 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            bus.push = 1'b1; bus.data_in = 8'(8'hD0 + i);
            step();
        end
        idle();
        for (int i = 0; i < 3; i++) begin
            bus.pop = 1'b1;
            step();
            chk_data("recov_pop_data", 8'(8'hD0 + i));
        end
        idle();
        chk_flags("recov_final", 1'b1, 1'b0);
        $display("test_reset_recovery done: compared=%0d mismatched=%0d", n_cmp, n_err);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b0;
        bus.push = 1'b0;
        bus.pop = 1'b0;
        bus.data_in = 8'h00;
        test_reset();
        test_ordered();
        test_overflow();
        test_underflow();
        test_simultaneous();
        test_wrap();
        test_reset_recovery();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation still running at %0t, required completion", $time);
        $fatal(1, "timeout");
    end
endmodule
